board_row_server: RTL and testbench

Responder side of the display row-fetch interface. On each request from the VGA colour path (`LD_Row` plus `rowNum`), it reads one board row of cells from the synchronous board RAM. It assembles the row in a shadow buffer, then updates the `Row` output array atomically and pulses `rowReady`. It sits between the game-board RAM and the colour path, and hides RAM read latency inside horizontal blanking.

---
 rtl/board_pkg.sv | 18 +
 rtl/board_row_server_rise_detect.sv | 23 ++
 rtl/board_row_server.sv | 181 ++++++++++++++++++
 tb/tb_board_row_server.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// Shared board geometry, cell/row types and the row-fetch state encoding.
package board_pkg;

  localparam int unsigned BOARD_W = 10;
  localparam int unsigned BOARD_H = 20;
  localparam int unsigned CELL_W  = 16;
  localparam int unsigned ADDR_W  = 8;

  typedef logic [CELL_W-1:0] cell_t;
  typedef cell_t row_t [BOARD_W];

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } fetch_state_t;

endpackage

// File: rtl/board_row_server_rise_detect.sv
// Turns the LD_Row request level into a single-cycle request pulse.
module rise_detect
  import board_pkg::*;
(
  input  logic Clk,
  input  logic reset,
  input  logic ld_i,
  output logic rise_o
);

  logic ld_q;

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      ld_q <= 1'b0;
    end else begin
      ld_q <= ld_i;
    end
  end

  assign rise_o = ld_i & ~ld_q;

endmodule

// File: rtl/board_row_server.sv
// Fetches one board row from synchronous RAM into a shadow buffer and commits it atomically.
module board_row_server #(
  parameter int unsigned BOARD_W = board_pkg::BOARD_W,
  parameter int unsigned BOARD_H = board_pkg::BOARD_H,
  parameter int unsigned CELL_W  = board_pkg::CELL_W,
  parameter int unsigned ADDR_W  = board_pkg::ADDR_W
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              LD_Row,
  input  logic [7:0]        rowNum,
  output logic [CELL_W-1:0] Row [BOARD_W],
  output logic              rowReady,
  output logic              ram_rd,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [CELL_W-1:0] ram_rdata
);
  import board_pkg::*;

  localparam int unsigned ColW = $clog2(BOARD_W + 1);

  fetch_state_t      state_q, state_d;
  logic [ColW-1:0]   col_q, col_d;
  logic [7:0]        row_q, row_d;
  logic              pend_q, pend_d;
  logic [7:0]        pend_row_q, pend_row_d;
  logic              rd_q, rd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ColW-1:0]   iss_col_q, iss_col_d;
  logic              dv_q;
  logic [ColW-1:0]   dcol_q;
  logic              ready_q, ready_d;
  logic [CELL_W-1:0] shadow_q  [BOARD_W];
  logic [CELL_W-1:0] row_out_q [BOARD_W];

  logic       rise;
  logic       start;
  logic       commit;
  logic       blank;
  logic [7:0] start_row;

  rise_detect u_rise_detect (
    .Clk    (Clk),
    .reset  (reset),
    .ld_i   (LD_Row),
    .rise_o (rise)
  );

  // Shift-and-add for the default 10-wide board keeps the address path multiplier-free.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [7:0] r, input logic [ColW-1:0] c);
    logic [ADDR_W-1:0] base;
    if (BOARD_W == 10) begin
      base = (ADDR_W'(r) << 3) + (ADDR_W'(r) << 1);
    end else begin
      base = ADDR_W'(32'(r) * BOARD_W);
    end
    return base + ADDR_W'(c);
  endfunction

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    pend_d     = pend_q;
    pend_row_d = pend_row_q;
    rd_d       = 1'b0;
    addr_d     = addr_q;
    iss_col_d  = iss_col_q;
    ready_d    = 1'b0;
    start      = 1'b0;
    commit     = 1'b0;
    blank      = 1'b0;
    // A fresh rise always beats an older pending request.
    start_row  = rise ? rowNum : pend_row_q;

    unique case (state_q)
      IDLE: begin
        if (rise || pend_q) begin
          pend_d = 1'b0;
          if (32'(start_row) < BOARD_H) begin
            start = 1'b1;
          end else begin
            blank   = 1'b1;
            ready_d = 1'b1;
          end
        end
      end
      FETCH: begin
        if (rise) begin
          pend_d     = 1'b1;
          pend_row_d = rowNum;
        end
        if (col_q == ColW'(BOARD_W)) begin
          state_d = DRAIN;
        end else begin
          rd_d      = 1'b1;
          addr_d    = cell_addr(row_q, col_q);
          iss_col_d = col_q;
          col_d     = col_q + ColW'(1);
        end
      end
      DRAIN: begin
        commit  = 1'b1;
        ready_d = 1'b1;
        state_d = IDLE;
        if (rise || pend_q) begin
          if (32'(start_row) < BOARD_H) begin
            start  = 1'b1;
            pend_d = 1'b0;
          end else begin
            // Invalid follow-on row is blanked from IDLE on the next edge.
            pend_d     = 1'b1;
            pend_row_d = start_row;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      state_d   = FETCH;
      row_d     = start_row;
      rd_d      = 1'b1;
      addr_d    = cell_addr(start_row, '0);
      iss_col_d = '0;
      col_d     = ColW'(1);
    end
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      col_q      <= '0;
      row_q      <= '0;
      pend_q     <= 1'b0;
      pend_row_q <= '0;
      rd_q       <= 1'b0;
      addr_q     <= '0;
      iss_col_q  <= '0;
      dv_q       <= 1'b0;
      dcol_q     <= '0;
      ready_q    <= 1'b0;
      for (int unsigned i = 0; i < BOARD_W; i++) begin
        shadow_q[i]  <= '0;
        row_out_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      pend_q     <= pend_d;
      pend_row_q <= pend_row_d;
      rd_q       <= rd_d;
      addr_q     <= addr_d;
      iss_col_q  <= iss_col_d;
      dv_q       <= rd_q;
      dcol_q     <= iss_col_q;
      ready_q    <= ready_d;
      if (dv_q) begin
        shadow_q[dcol_q] <= ram_rdata;
      end
      // The last cell is taken straight from the RAM port on the commit edge.
      if (commit) begin
        for (int unsigned i = 0; i < BOARD_W - 1; i++) begin
          row_out_q[i] <= shadow_q[i];
        end
        row_out_q[BOARD_W-1] <= ram_rdata;
      end else if (blank) begin
        for (int unsigned i = 0; i < BOARD_W; i++) begin
          row_out_q[i] <= '0;
        end
      end
    end
  end

  assign Row      = row_out_q;
  assign rowReady = ready_q;
  assign ram_rd   = rd_q;
  assign ram_addr = addr_q;

endmodule

// File: tb/tb_board_row_server.sv
// Directed bench for board_row_server with a synchronous board RAM model.
module tb_board_row_server;

  logic        Clk;
  logic        reset;
  logic        LD_Row;
  logic [7:0]  rowNum;
  logic [15:0] Row [10];
  logic        rowReady;
  logic        ram_rd;
  logic [7:0]  ram_addr;
  logic [15:0] ram_rdata;

  int passed;
  int failed;
  int total;
  int cyc;
  int ready_cnt;
  logic [7:0] addr_log[$];
  int ready_times[$];

  board_row_server dut (
    .Clk       (Clk),
    .reset     (reset),
    .LD_Row    (LD_Row),
    .rowNum    (rowNum),
    .Row       (Row),
    .rowReady  (rowReady),
    .ram_rd    (ram_rd),
    .ram_addr  (ram_addr),
    .ram_rdata (ram_rdata)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [15:0] cell_of(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] c;
    r = a / 8'd10;
    c = a % 8'd10;
    return {4'h0, r[3:0], c[3:0], 4'hA};
  endfunction

  // Data is only valid the cycle after the address; otherwise garbage.
  always @(posedge Clk) begin
    ram_rdata <= ram_rd ? cell_of(ram_addr) : 16'hDEAD;
  end

  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    if (ram_rd) addr_log.push_back(ram_addr);
    if (rowReady) begin
      ready_cnt = ready_cnt + 1;
      ready_times.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  function automatic logic row_zero();
    logic z;
    z = 1'b1;
    for (int i = 0; i < 10; i++) if (Row[i] !== 16'h0) z = 1'b0;
    return z;
  endfunction

  task automatic clear_logs();
    addr_log.delete();
    ready_times.delete();
    ready_cnt = 0;
  endtask

  initial begin
    passed = 0; failed = 0; total = 0; cyc = 0; ready_cnt = 0;
    reset = 1'b1; LD_Row = 1'b0; rowNum = 8'd0;

    // Reset state
    step(3);
    check("rst_row_zero", 32'(row_zero()), 32'd1);
    check("rst_ready", 32'(rowReady), 32'd0);
    check("rst_ram_rd", 32'(ram_rd), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    reset = 1'b0;
    step(2);
    clear_logs();

    // Single fetch of row 7
    LD_Row = 1'b1; rowNum = 8'd7;
    step(1);  // E0
    check("r7_e0_rd", 32'(ram_rd), 32'd1);
    check("r7_e0_addr", 32'(ram_addr), 32'd70);
    LD_Row = 1'b0;
    step(10); // E10
    check("r7_e10_rd", 32'(ram_rd), 32'd0);
    check("r7_e10_ready", 32'(rowReady), 32'd0);
    step(1);  // E11
    check("r7_e11_ready", 32'(rowReady), 32'd1);
    check("r7_row0", 32'(Row[0]), 32'h070A);
    check("r7_row3", 32'(Row[3]), 32'h073A);
    check("r7_row9", 32'(Row[9]), 32'h079A);
    step(1);  // E12
    check("r7_e12_ready", 32'(rowReady), 32'd0);
    check("r7_nreads", 32'(addr_log.size()), 32'd10);
    for (int i = 0; i < 10; i++) check("r7_addr_seq", 32'(addr_log[i]), 32'(70 + i));

    // Held level: one fetch only
    clear_logs();
    LD_Row = 1'b1; rowNum = 8'd2;
    step(40);
    LD_Row = 1'b0;
    step(5);
    check("hold_nreads", 32'(addr_log.size()), 32'd10);
    check("hold_first", 32'(addr_log[0]), 32'd20);
    check("hold_last", 32'(addr_log[9]), 32'd29);
    check("hold_ready_cnt", 32'(ready_cnt), 32'd1);
    check("hold_row5", 32'(Row[5]), 32'h025A);

    // Row 4, then invalid row 20
    LD_Row = 1'b1; rowNum = 8'd4;
    step(1);
    LD_Row = 1'b0;
    step(14);
    check("r4_row2", 32'(Row[2]), 32'h042A);
    clear_logs();
    LD_Row = 1'b1; rowNum = 8'd20;
    step(1);  // E0
    check("blank_ready_e0", 32'(rowReady), 32'd1);
    check("blank_row_zero", 32'(row_zero()), 32'd1);
    LD_Row = 1'b0;
    step(5);
    check("blank_no_reads", 32'(addr_log.size()), 32'd0);
    check("blank_ready_cnt", 32'(ready_cnt), 32'd1);

    // Pending overwrite: row 1, then 3, then 19 during fetch
    clear_logs();
    LD_Row = 1'b1; rowNum = 8'd1;
    step(1);
    LD_Row = 1'b0;
    step(2);
    LD_Row = 1'b1; rowNum = 8'd3;
    step(1);
    LD_Row = 1'b0;
    step(1);
    LD_Row = 1'b1; rowNum = 8'd19;
    step(1);
    LD_Row = 1'b0;
    step(40);
    check("pend_nreads", 32'(addr_log.size()), 32'd20);
    check("pend_first_row", 32'(addr_log[0]), 32'd10);
    check("pend_row1_last", 32'(addr_log[9]), 32'd19);
    check("pend_row19_first", 32'(addr_log[10]), 32'd190);
    check("pend_row19_last", 32'(addr_log[19]), 32'd199);
    check("pend_ready_cnt", 32'(ready_cnt), 32'd2);
    check("pend_row_final", 32'(Row[7]), 32'h037A);

    // Boundary: row 19 then row 0 back to back
    clear_logs();
    LD_Row = 1'b1; rowNum = 8'd19;
    step(1);
    LD_Row = 1'b0;
    step(1);
    LD_Row = 1'b1; rowNum = 8'd0;
    step(1);
    LD_Row = 1'b0;
    step(30);
    check("bnd_nreads", 32'(addr_log.size()), 32'd20);
    check("bnd_max_addr", 32'(addr_log[9]), 32'd199);
    check("bnd_wrap_first", 32'(addr_log[10]), 32'd0);
    check("bnd_last", 32'(addr_log[19]), 32'd9);
    check("bnd_ready_cnt", 32'(ready_cnt), 32'd2);
    check("bnd_ready_gap", 32'(ready_times[1] - ready_times[0]), 32'd11);
    check("bnd_row0", 32'(Row[0]), 32'h000A);
    check("bnd_row9", 32'(Row[9]), 32'h009A);

    // Reset mid-fetch of row 5
    LD_Row = 1'b1; rowNum = 8'd5;
    step(1);
    LD_Row = 1'b0;
    step(3);
    check("mid_rd_before", 32'(ram_rd), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_row_zero", 32'(row_zero()), 32'd1);
    check("mid_ready", 32'(rowReady), 32'd0);
    check("mid_ram_rd", 32'(ram_rd), 32'd0);
    step(2);
    reset = 1'b0;
    clear_logs();
    step(20);
    check("post_rst_ready", 32'(ready_cnt), 32'd0);
    check("post_rst_reads", 32'(addr_log.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
